board_store: RTL and testbench

- Playfield memory on the other end of the piece-shape encoder.
- Consumes the encoder's four linear cell indices and its piece colour.
- Tests them for collision against the stored 10x20 board, and commits them on request.
- Clears completed rows after a commit and serves a colour read port to the VGA renderer.

---
 rtl/board_store_if.sv | 33 +++
 rtl/board_store.sv | 193 +++++++++++++++++++
 tb/tb_board_store.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/board_store_if.sv
// Request/result bus between the piece controller, the board store and the renderer.
// Latency: none, plain wires grouped for port connection.
// Backpressure: none; the requester watches busy/done, req is dropped while busy.
interface board_store_if;
  logic        req;
  logic        op;
  logic [11:0] w_color;
  logic [7:0]  color_pos1;
  logic [7:0]  color_pos2;
  logic [7:0]  color_pos3;
  logic [7:0]  color_pos4;
  logic        board_clr;
  logic        busy;
  logic        done;
  logic        collide;
  logic [2:0]  lines_cleared;
  logic [7:0]  rd_addr;
  logic [11:0] rd_color;

  // Requester / renderer side.
  modport master (
    output req, op, w_color, color_pos1, color_pos2, color_pos3, color_pos4,
           board_clr, rd_addr,
    input  busy, done, collide, lines_cleared, rd_color
  );

  // Board store side.
  modport slave (
    input  req, op, w_color, color_pos1, color_pos2, color_pos3, color_pos4,
           board_clr, rd_addr,
    output busy, done, collide, lines_cleared, rd_color
  );
endinterface

// File: rtl/board_store.sv
// Playfield store: collision test, piece commit, optional row clearing, renderer read port.
// Latency: done 2 cycles after accept for CHECK or a colliding COMMIT; 3 for a clean COMMIT,
//   plus a bottom-to-top row scan and row shifting when LINE_CLEAR_EN is defined.
// Backpressure: req is sampled only in IDLE; requests while busy are dropped, not queued.
module board_store #(
  parameter int COLS = 10,
  parameter int ROWS = 20
) (
  input logic          clk,
  input logic          rst,
  board_store_if.slave bus
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = 8;
  localparam logic [AW-1:0] NCELLS = AW'(CELLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WRITE,
    S_SCAN,
    S_SHIFT,
    S_FIN
  } state_t;

  state_t        state_q;
  logic          op_q;
  logic [11:0]   color_q;
  logic [AW-1:0] pos_q [4];
  logic          busy_q;
  logic          done_q;
  logic          collide_q;
  logic [2:0]    lines_q;
  logic [11:0]   rd_color_q;
  logic [11:0]   cells_q [CELLS];
  logic          collide_d;

`ifdef LINE_CLEAR_EN
  localparam int RW = $clog2(ROWS);

  logic [RW-1:0] row_q;      // row being scanned, counts from the bottom upward
  logic [RW-1:0] k_q;        // destination row of the current shift step
  logic          row_full;

  // Linear index of (row, column).
  function automatic logic [AW-1:0] cidx(input logic [RW-1:0] r, input int c);
    return AW'(r) * AW'(COLS) + AW'(c);
  endfunction

  // A row is full when none of its cells holds the empty colour.
  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (cells_q[cidx(row_q, c)] == 12'h000) row_full = 1'b0;
    end
  end
`endif

  // Collision: any piece cell off the board (wrapped indices land >= CELLS) or already occupied.
  always_comb begin
    collide_d = 1'b0;
    for (int p = 0; p < 4; p++) begin
      if (pos_q[2'(p)] >= NCELLS) begin
        collide_d = 1'b1;
      end else if (cells_q[pos_q[2'(p)]] != 12'h000) begin
        collide_d = 1'b1;
      end
    end
  end

  // Operation FSM together with the board storage it reads and modifies.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= 1'b0;
      color_q   <= 12'h000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      collide_q <= 1'b0;
      lines_q   <= 3'd0;
      for (int p = 0; p < 4; p++) pos_q[2'(p)] <= '0;
      for (int i = 0; i < CELLS; i++) cells_q[AW'(i)] <= 12'h000;
`ifdef LINE_CLEAR_EN
      row_q <= '0;
      k_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req) begin
            // A request takes priority over a simultaneous board wipe.
            op_q      <= bus.op;
            color_q   <= bus.w_color;
            pos_q[0]  <= bus.color_pos1;
            pos_q[1]  <= bus.color_pos2;
            pos_q[2]  <= bus.color_pos3;
            pos_q[3]  <= bus.color_pos4;
            busy_q    <= 1'b1;
            collide_q <= 1'b0;
            lines_q   <= 3'd0;
            state_q   <= S_CHECK;
          end else if (bus.board_clr) begin
            for (int i = 0; i < CELLS; i++) cells_q[AW'(i)] <= 12'h000;
          end
        end

        S_CHECK: begin
          if (!op_q || collide_d) begin
            collide_q <= collide_d;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_FIN;
          end else begin
            state_q <= S_WRITE;
          end
        end

        S_WRITE: begin
          // Duplicate indices simply write the same colour twice.
          for (int p = 0; p < 4; p++) cells_q[pos_q[2'(p)]] <= color_q;
`ifdef LINE_CLEAR_EN
          row_q   <= RW'(ROWS - 1);
          state_q <= S_SCAN;
`else
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_FIN;
`endif
        end

`ifdef LINE_CLEAR_EN
        S_SCAN: begin
          if (row_full) begin
            if (lines_q != 3'd7) lines_q <= lines_q + 3'd1;
            k_q     <= row_q;
            state_q <= S_SHIFT;
          end else if (row_q != '0) begin
            row_q <= row_q - RW'(1);
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end
        end

        S_SHIFT: begin
          // Pull the row above down one step; the top row is emptied on the last step.
          if (k_q != '0) begin
            for (int c = 0; c < COLS; c++) begin
              cells_q[cidx(k_q, c)] <= cells_q[cidx(k_q - RW'(1), c)];
            end
          end
          if (k_q <= RW'(1)) begin
            for (int c = 0; c < COLS; c++) cells_q[AW'(c)] <= 12'h000;
            // row_q is unchanged so the shifted-down content is rescanned.
            state_q <= S_SCAN;
          end else begin
            k_q <= k_q - RW'(1);
          end
        end
`endif

        S_FIN: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Renderer read port, one cycle latency, free-running in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_color_q <= 12'h000;
    end else if (bus.rd_addr < NCELLS) begin
      rd_color_q <= cells_q[bus.rd_addr];
    end else begin
      rd_color_q <= 12'h000;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.collide       = collide_q;
  assign bus.lines_cleared = lines_q;
  assign bus.rd_color      = rd_color_q;

endmodule

// File: tb/tb_board_store.sv
module tb_board_store;
  localparam int COLS  = 10;
  localparam int ROWS  = 20;
  localparam int CELLS = COLS * ROWS;

  typedef struct {
    logic       col;
    logic [2:0] lc;
    int         lat;   // expected accept-to-done cycles, 0 when not checked
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  board_store_if bus ();

  board_store #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int           tests = 0;
  int           fails = 0;
  logic [11:0]  model [CELLS];
  exp_t         opq [$];
  logic [11:0]  rdq [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < CELLS; i++) model[i] = 12'h000;
  endtask

  // Reference behaviour: collision test, write, then compact away full rows.
  task automatic model_op(input logic op, input logic [11:0] col,
                          input logic [7:0] p0, input logic [7:0] p1,
                          input logic [7:0] p2, input logic [7:0] p3, output exp_t e);
    logic [7:0] p [4];
    int lc;
    int dst;
    bit full;
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    e.col = 1'b0;
    lc = 0;
    for (int i = 0; i < 4; i++) begin
      if (int'(p[i]) >= CELLS) e.col = 1'b1;
      else if (model[p[i]] != 12'h000) e.col = 1'b1;
    end
    if (op && !e.col) begin
      for (int i = 0; i < 4; i++) model[p[i]] = col;
`ifdef LINE_CLEAR_EN
      dst = ROWS - 1;
      for (int src = ROWS - 1; src >= 0; src--) begin
        full = 1'b1;
        for (int x = 0; x < COLS; x++) if (model[src*COLS+x] == 12'h000) full = 1'b0;
        if (full) begin
          lc++;
        end else begin
          if (dst != src) for (int x = 0; x < COLS; x++) model[dst*COLS+x] = model[src*COLS+x];
          dst--;
        end
      end
      for (int r = dst; r >= 0; r--) for (int x = 0; x < COLS; x++) model[r*COLS+x] = 12'h000;
`endif
    end
    e.lc = (lc > 7) ? 3'd7 : 3'(lc);
    if (!op || e.col) e.lat = 2;
`ifdef LINE_CLEAR_EN
    else e.lat = (lc == 0) ? 3 + ROWS : 0;
`else
    else e.lat = 3;
`endif
  endtask

  // Read every address (and some beyond the board); expectation queued when the address is driven.
  task automatic read_sweep(input string tag);
    for (int a = 0; a < 210; a++) begin
      bus.rd_addr = 8'(a);
      rdq.push_back((a < CELLS) ? model[a] : 12'h000);
      @(posedge clk); #1;
      check(tag, {20'h0, bus.rd_color}, {20'h0, rdq.pop_front()});
    end
    bus.rd_addr = 8'd0;
  endtask

  task automatic do_op(input string tag, input logic op, input logic [11:0] col,
                       input logic [7:0] p0, input logic [7:0] p1,
                       input logic [7:0] p2, input logic [7:0] p3,
                       input bit spurious, input bit clr_too);
    exp_t e;
    exp_t got;
    int n;
    model_op(op, col, p0, p1, p2, p3, e);
    opq.push_back(e);
    bus.req = 1'b1; bus.op = op; bus.w_color = col; bus.board_clr = clr_too;
    bus.color_pos1 = p0; bus.color_pos2 = p1; bus.color_pos3 = p2; bus.color_pos4 = p3;
    @(posedge clk); #1;
    bus.board_clr = 1'b0;
    if (spurious) begin
      bus.op = 1'b1; bus.w_color = 12'hbad;
      bus.color_pos1 = 8'd100; bus.color_pos2 = 8'd101; bus.color_pos3 = 8'd102; bus.color_pos4 = 8'd103;
    end else begin
      bus.req = 1'b0;
    end
    n = 1;
    check({tag, "_busy"}, bus.busy, 1);
    while (bus.done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    bus.req = 1'b0;
    got = opq.pop_front();
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_busy_fin"}, bus.busy, 0);
    check({tag, "_collide"}, bus.collide, got.col);
    check({tag, "_lines"}, bus.lines_cleared, got.lc);
    if (got.lat > 0) check({tag, "_latency"}, n, got.lat);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, bus.done, 0);
    check({tag, "_collide_hold"}, bus.collide, got.col);
    if (spurious) begin
      repeat (3) begin
        @(posedge clk); #1;
        check({tag, "_req_ignored"}, bus.busy, 0);
      end
    end
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    bus.req = 1'b0; bus.op = 1'b0; bus.w_color = 12'h000; bus.board_clr = 1'b0;
    bus.color_pos1 = 8'd0; bus.color_pos2 = 8'd0; bus.color_pos3 = 8'd0; bus.color_pos4 = 8'd0;
    bus.rd_addr = 8'd0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_collide", bus.collide, 0);
    check("rst_lines", bus.lines_cleared, 0);
    check("rst_rd_color", bus.rd_color, 0);
    rst = 1'b0;
    read_sweep("rd_after_reset");

    do_op("check_empty", 1'b0, 12'hd7d, 8'd195, 8'd194, 8'd196, 8'd185, 1'b0, 1'b0);
    read_sweep("rd_after_check");
    do_op("commit_t", 1'b1, 12'hd7d, 8'd195, 8'd194, 8'd196, 8'd185, 1'b0, 1'b0);
    read_sweep("rd_after_t");
    do_op("commit_t_again", 1'b1, 12'h123, 8'd195, 8'd194, 8'd196, 8'd185, 1'b0, 1'b0);
    do_op("check_oor", 1'b0, 12'h456, 8'd246, 8'd5, 8'd6, 8'd7, 1'b0, 1'b0);
    do_op("commit_oor", 1'b1, 12'h456, 8'd246, 8'd5, 8'd6, 8'd7, 1'b0, 1'b0);
    read_sweep("rd_after_oor");

    // Wipe the board, then build a nearly full bottom row with one marker cell above it.
    bus.board_clr = 1'b1;
    @(posedge clk); #1;
    bus.board_clr = 1'b0;
    check("clr_busy", bus.busy, 0);
    check("clr_done", bus.done, 0);
    model_clear();
    do_op("preload_a", 1'b1, 12'hf00, 8'd190, 8'd191, 8'd192, 8'd193, 1'b0, 1'b0);
    do_op("preload_b", 1'b1, 12'h0f0, 8'd194, 8'd195, 8'd195, 8'd194, 1'b0, 1'b0);
    do_op("preload_c", 1'b1, 12'h00f, 8'd185, 8'd185, 8'd185, 8'd185, 1'b0, 1'b0);
    read_sweep("rd_after_preload");
    do_op("commit_i", 1'b1, 12'h0ff, 8'd197, 8'd196, 8'd198, 8'd199, 1'b0, 1'b0);
    read_sweep("rd_after_line");

    // Reset in the middle of a commit (during row shifting when clearing is built in).
`ifdef LINE_CLEAR_EN
    do_op("fill_a", 1'b1, 12'h111, 8'd190, 8'd191, 8'd192, 8'd193, 1'b0, 1'b0);
    do_op("fill_b", 1'b1, 12'h222, 8'd194, 8'd196, 8'd197, 8'd198, 1'b0, 1'b0);
    bus.color_pos1 = 8'd199;
`else
    bus.color_pos1 = 8'd3;
`endif
    bus.color_pos2 = 8'd0; bus.color_pos3 = 8'd1; bus.color_pos4 = 8'd2;
    bus.req = 1'b1; bus.op = 1'b1; bus.w_color = 12'h333;
    @(posedge clk); #1;
    bus.req = 1'b0;
`ifdef LINE_CLEAR_EN
    repeat (4) @(posedge clk);
`else
    repeat (1) @(posedge clk);
`endif
    #1;
    check("mid_busy", bus.busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_lines", bus.lines_cleared, 0);
    rst = 1'b0;
    model_clear();
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen++;
    end
    check("mid_rst_no_done", seen, 0);
    read_sweep("rd_after_mid_rst");

    do_op("busy_req", 1'b1, 12'h444, 8'd10, 8'd11, 8'd12, 8'd13, 1'b1, 1'b0);
    do_op("req_with_clr", 1'b1, 12'h555, 8'd20, 8'd21, 8'd22, 8'd23, 1'b0, 1'b1);
    read_sweep("rd_after_req_clr");
    bus.board_clr = 1'b1;
    @(posedge clk); #1;
    bus.board_clr = 1'b0;
    model_clear();
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    check("clr_quiet", seen, 0);
    read_sweep("rd_after_clr");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
